// File: rtl/loong_mix_pkg.sv
// Shared types, defaults and cell-index helpers for the LOONG mix layer.
package loong_mix_pkg;

  typedef enum logic [1:0] {IDLE, CALC, HOLD} mix_state_e;

  localparam int unsigned CELLS    = 16;
  localparam int unsigned DEF_W    = 4;
  localparam logic [3:0]  DEF_POLY = 4'h3;
  localparam logic [15:0] DEF_COEF = {4'd13, 4'd9, 4'd4, 4'd1};

  typedef logic [3:0] cell_idx_t;
  typedef logic [1:0] cell_pos_t;

  function automatic cell_idx_t cell_idx(input cell_pos_t r, input cell_pos_t c);
    return {r, c};
  endfunction

  function automatic cell_pos_t cell_row(input cell_idx_t i);
    return i[3:2];
  endfunction

  function automatic cell_pos_t cell_col(input cell_idx_t i);
    return i[1:0];
  endfunction

endpackage

// File: rtl/loong_gf_mul.sv
// Combinational GF(2^W) multiplier: MSB-first shift-and-add with POLY reduction.
module loong_gf_mul
  import loong_mix_pkg::*;
#(
  parameter int unsigned  W    = DEF_W,
  parameter logic [W-1:0] POLY = W'(DEF_POLY)
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p
);

  always_comb begin
    logic [W-1:0] acc;
    acc = '0;
    for (int i = int'(W) - 1; i >= 0; i--) begin
      acc = {acc[W-2:0], 1'b0} ^ (acc[W-1] ? POLY : '0);
      if (b[i]) acc = acc ^ a;
    end
    p = acc;
  end

endmodule

// File: rtl/loong_mix_layer.sv
// Iterative 4x4 mix layer over GF(2^W), LANES output cells per cycle.
// Column mixing is built only when LOONG_MIX_COL_EN is defined; otherwise in_col is ignored.
module loong_mix_layer
  import loong_mix_pkg::*;
#(
  parameter int unsigned    W     = DEF_W,
  parameter logic [W-1:0]   POLY  = W'(DEF_POLY),
  parameter logic [4*W-1:0] COEF  = (4*W)'(DEF_COEF),
  parameter int unsigned    LANES = 1
) (
  input  logic            clock,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_col,
  input  logic [16*W-1:0] in_state,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [16*W-1:0] out_state
);

  typedef logic [W-1:0] cell_t;

  localparam logic [4:0] LAST_IDX = 5'(CELLS - LANES);
  localparam logic [4:0] STEP     = 5'(LANES);

  mix_state_e      state_q, state_d;
  logic [16*W-1:0] buf_q;
  logic [4:0]      idx_q;
  logic            accept;
  logic            col_q;
  cell_t           res      [LANES];
  cell_idx_t       lane_idx [LANES];

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (idx_q == LAST_IDX) state_d = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_d = in_valid ? CALC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Capture stage: the buffer decouples the producer from the iterative datapath
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      buf_q <= '0;
      idx_q <= '0;
    end else if (accept) begin
      buf_q <= in_state;
      idx_q <= '0;
    end else if (state_q == CALC) begin
      idx_q <= idx_q + STEP;
    end
  end

`ifdef LOONG_MIX_COL_EN
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)        col_q <= 1'b0;
    else if (accept) col_q <= in_col;
  end
`else
  logic unused_in_col;
  assign unused_in_col = in_col;
  assign col_q         = 1'b0;
`endif

  // Compute stage: each lane forms one output cell from four GF products
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    cell_pos_t r, c;
    cell_t     prod [4];

    assign lane_idx[k] = idx_q[3:0] + cell_idx_t'(k);
    assign r           = cell_row(lane_idx[k]);
    assign c           = cell_col(lane_idx[k]);

    for (genvar l = 0; l < 4; l++) begin : g_term
      localparam cell_pos_t LP = cell_pos_t'(l);
      cell_t op_a, op_b;

      always_comb begin
        op_a = buf_q[cell_idx(r, LP)*W +: W];
        op_b = COEF[(LP ^ c)*W +: W];
`ifdef LOONG_MIX_COL_EN
        if (col_q) begin
          op_a = COEF[(r ^ LP)*W +: W];
          op_b = buf_q[cell_idx(LP, c)*W +: W];
        end
`endif
      end

      loong_gf_mul #(.W(W), .POLY(POLY)) u_mul (
        .a(op_a),
        .b(op_b),
        .p(prod[l])
      );
    end

    assign res[k] = prod[0] ^ prod[1] ^ prod[2] ^ prod[3];
  end

  // Output stage: result cells land in raster order and hold through HOLD
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out_state <= '0;
    end else if (state_q == CALC) begin
      for (int k = 0; k < int'(LANES); k++) begin
        out_state[lane_idx[k]*W +: W] <= res[k];
      end
    end
  end

endmodule

// File: tb/tb_loong_mix_layer.sv
// Self-checking bench for loong_mix_layer: four instances (LANES 1, 2, 4, 16) against a behavioural model.
module tb_loong_mix_layer;

  localparam int NI = 4;
  localparam int LN [NI] = '{1, 2, 4, 16};

`ifdef LOONG_MIX_COL_EN
  localparam bit          COL_EN   = 1'b1;
  localparam logic [63:0] EXP_COL1 = 64'h000D_0009_0004_0001;
`else
  localparam bit          COL_EN   = 1'b0;
  localparam logic [63:0] EXP_COL1 = 64'h0000_0000_0000_D941;
`endif

  logic clock = 1'b0;
  logic rst   = 1'b0;
  logic [NI-1:0]       in_valid_v, in_ready_v, in_col_v, out_valid_v, out_ready_v;
  logic [NI-1:0][63:0] in_state_v, out_state_v;

  int n_pass  = 0;
  int n_total = 0;
  bit checking = 1'b0;

  initial forever #5 clock = ~clock;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    loong_mix_layer #(.W(4), .POLY(4'h3), .COEF(16'hD941), .LANES(LN[g])) u_dut (
      .clock    (clock),
      .rst      (rst),
      .in_valid (in_valid_v[g]),
      .in_ready (in_ready_v[g]),
      .in_col   (in_col_v[g]),
      .in_state (in_state_v[g]),
      .out_valid(out_valid_v[g]),
      .out_ready(out_ready_v[g]),
      .out_state(out_state_v[g])
    );
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Polynomial product then reduction modulo x^4+x+1.
  function automatic logic [3:0] m_gmul(input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 7; i >= 4; i--) if (p[i]) p = p ^ (8'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic logic [63:0] m_mix(input logic [63:0] s, input logic col);
    logic [3:0]  h [4];
    logic [3:0]  a [4][4];
    logic [3:0]  o;
    logic [63:0] res;
    logic        ce;
    h   = '{4'd1, 4'd4, 4'd9, 4'd13};
    ce  = col && COL_EN;
    res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        a[r][c] = s[(4*r+c)*4 +: 4];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        o = '0;
        for (int l = 0; l < 4; l++)
          o = o ^ (ce ? m_gmul(h[r^l], a[l][c]) : m_gmul(a[r][l], h[l^c]));
        res[(4*r+c)*4 +: 4] = o;
      end
    return res;
  endfunction

  // Transaction-level model: cycles left in compute, whether a result is on offer.
  int          calc_left [NI] = '{default: 0};
  bit          have      [NI] = '{default: 1'b0};
  logic [63:0] pend      [NI] = '{default: 64'd0};
  logic [63:0] shown     [NI] = '{default: 64'd0};

  function automatic bit m_ready(input int d);
    return (calc_left[d] == 0 && !have[d]) || (have[d] && out_ready_v[d]);
  endfunction

  always @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < NI; d++) begin
        calc_left[d] = 0;
        have[d]      = 1'b0;
      end
    end else begin
      for (int d = 0; d < NI; d++) begin
        bit acc;
        acc = in_valid_v[d] && m_ready(d);
        if (have[d] && out_ready_v[d]) have[d] = 1'b0;
        if (calc_left[d] > 0) begin
          calc_left[d]--;
          if (calc_left[d] == 0) begin
            have[d]  = 1'b1;
            shown[d] = pend[d];
          end
        end
        if (acc) begin
          pend[d]      = m_mix(in_state_v[d], in_col_v[d]);
          calc_left[d] = 16 / LN[d];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (rst && checking) begin
      for (int d = 0; d < NI; d++) begin
        chk($sformatf("L%0d out_valid", LN[d]), 64'(out_valid_v[d]), 64'(have[d]));
        chk($sformatf("L%0d in_ready", LN[d]), 64'(in_ready_v[d]), 64'(m_ready(d)));
        if (have[d]) chk($sformatf("L%0d out_state", LN[d]), out_state_v[d], shown[d]);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int d, input logic [63:0] s, input logic c);
    int n;
    n = 0;
    in_valid_v[d] = 1'b1;
    in_state_v[d] = s;
    in_col_v[d]   = c;
    while (!in_ready_v[d] && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("L%0d accepted in time", LN[d]), 64'(n < 100), 64'd1);
    tick();
    in_valid_v[d] = 1'b0;
    in_state_v[d] = {$urandom, $urandom};
    in_col_v[d]   = ~c;
  endtask

  task automatic wait_out(input int d, output int lat);
    lat = 0;
    while (!out_valid_v[d] && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  task automatic run(input int d, input logic [63:0] s, input logic c, output logic [63:0] r);
    int lat;
    send(d, s, c);
    wait_out(d, lat);
    chk($sformatf("L%0d latency", LN[d]), 64'(lat), 64'(16 / LN[d]));
    r = out_state_v[d];
    out_ready_v[d] = 1'b1;
    tick();
    out_ready_v[d] = 1'b0;
  endtask

  initial begin
    logic [63:0] r, r2, s, s2, held;
    int          lat, d;
    logic        c;

    in_valid_v  = '0;
    in_col_v    = '0;
    out_ready_v = '0;
    in_state_v  = '0;
    repeat (3) @(posedge clock);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("L%0d reset in_ready", LN[i]), 64'(in_ready_v[i]), 64'd1);
      chk($sformatf("L%0d reset out_valid", LN[i]), 64'(out_valid_v[i]), 64'd0);
      chk($sformatf("L%0d reset out_state", LN[i]), out_state_v[i], 64'd0);
    end
    rst      = 1'b1;
    checking = 1'b1;

    chk("model row cell00=2", m_mix(64'h2, 1'b0), 64'h0000_0000_0000_9182);
    chk("model row cell12=3", m_mix(64'h0300_0000, 1'b0), 64'h0000_0000_C348_0000);
    chk("model col cell00=1", m_mix(64'h1, 1'b1), EXP_COL1);

    run(0, 64'h2, 1'b0, r);
    chk("L1 row cell00=2", r, 64'h0000_0000_0000_9182);
    run(2, 64'h1, 1'b1, r);
    chk("L4 col cell00=1", r, EXP_COL1);
    run(2, 64'h1, 1'b0, r);
    chk("L4 row cell00=1", r, 64'h0000_0000_0000_D941);
    run(3, 64'h0300_0000, 1'b0, r);
    chk("L16 row cell12=3", r, 64'h0000_0000_C348_0000);

    for (int t = 0; t < 6; t++) begin
      d = (t < 2) ? 0 : (t < 4) ? 1 : 3;
      c = t[0];
      s = {$urandom, $urandom};
      run(d, s, c, r);
      run(d, r, c, r2);
      chk($sformatf("L%0d involution col=%0d", LN[d], c), r2, s);
    end

    s  = {$urandom, $urandom};
    s2 = {$urandom, $urandom};
    send(1, s, 1'b0);
    wait_out(1, lat);
    chk("L2 bp latency", 64'(lat), 64'd8);
    held = out_state_v[1];
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("L2 bp stable out_state", out_state_v[1], held);
      chk("L2 bp in_ready low", 64'(in_ready_v[1]), 64'd0);
      chk("L2 bp out_valid held", 64'(out_valid_v[1]), 64'd1);
    end
    in_valid_v[1]  = 1'b1;
    in_state_v[1]  = s2;
    in_col_v[1]    = 1'b0;
    out_ready_v[1] = 1'b1;
    #1;
    chk("L2 chain in_ready", 64'(in_ready_v[1]), 64'd1);
    tick();
    in_valid_v[1]  = 1'b0;
    out_ready_v[1] = 1'b0;
    chk("L2 chain out_valid drop", 64'(out_valid_v[1]), 64'd0);
    wait_out(1, lat);
    chk("L2 chain latency", 64'(lat), 64'd8);
    chk("L2 chain result", out_state_v[1], m_mix(s2, 1'b0));
    out_ready_v[1] = 1'b1;
    tick();
    out_ready_v[1] = 1'b0;

    send(0, 64'h2, 1'b0);
    repeat (7) tick();
    rst = 1'b0;
    #1;
    chk("L1 abort out_valid", 64'(out_valid_v[0]), 64'd0);
    chk("L1 abort out_state", out_state_v[0], 64'd0);
    chk("L1 abort in_ready", 64'(in_ready_v[0]), 64'd1);
    tick();
    rst = 1'b1;
    run(0, 64'h2, 1'b0, r);
    chk("L1 after abort", r, 64'h0000_0000_0000_9182);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_total);
    $fatal(1);
  end

endmodule
